// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the serial adder controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Digit-serial add/subtract controller: one 2-bit digit per cycle, LSB digit first.
//   state | meaning
//   IDLE  | waiting for start; last result held on sum/cout/ovf
//   RUN   | processing digit cnt_q, sum updates progressively
//   DONE  | one-cycle done pulse, then back to IDLE
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CW    = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, ovf_q;

  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_mid, c_out, last_dig;

  assign a_dig    = a_q[{cnt_q, 1'b0} +: DIGIT];
  assign b_dig    = b_q[{cnt_q, 1'b0} +: DIGIT];
  assign s_dig[0] = a_dig[0] ^ b_dig[0] ^ carry_q;
  assign c_mid    = (a_dig[0] & b_dig[0]) | (a_dig[0] & carry_q) | (b_dig[0] & carry_q);
  assign s_dig[1] = a_dig[1] ^ b_dig[1] ^ c_mid;
  assign c_out    = (a_dig[1] & b_dig[1]) | (a_dig[1] & c_mid) | (b_dig[1] & c_mid);
  assign last_dig = (cnt_q == CW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last_dig) state_d = DONE;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction runs as a + ~b + 1; cin only matters for add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        a_q     <= bus.a;
        b_q     <= bus.sub ? ~bus.b : bus.b;
        carry_q <= bus.sub ? 1'b1 : bus.cin;
        cnt_q   <= '0;
      end
    end else if (state_q == RUN) begin
      sum_q[{cnt_q, 1'b0} +: DIGIT] <= s_dig;
      carry_q                       <= c_out;
      if (last_dig) begin
        cnt_q  <= '0;
        cout_q <= c_out;
        ovf_q  <= c_mid ^ c_out;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule
